jelly_colormap_lut: RTL and testbench

- Programmable, multi-bank pixel colormap: maps an index stream (DATA_WIDTH bits) to COLOR_WIDTH-bit colours through a RAM lookup table.
- Successor to the fixed-table 8-bit colormap: generalises width, supports BANKS independently writable tables, and switches the active bank only at frame boundaries (tear-free palette swap).
- Sits in the video pipeline between a scalar/depth/heat source and the RGB output path.
- The stream side uses valid/ready with a stallable 2-stage pipeline; the cfg side is a simple synchronous write/update port.

---
 rtl/jelly_colormap_lut_if.sv | 34 +++
 rtl/jelly_colormap_lut.sv | 194 +++++++++++++++++++
 tb/tb_jelly_colormap_lut.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/jelly_colormap_lut_if.sv
// jelly_colormap_lut_if
//   Pixel stream bundle for the colormap LUT: index stream in (s_*) and
//   coloured stream out (m_*), both valid/ready.
//   Modports:
//     slave  - the LUT itself: consumes s_*, produces m_*
//     master - the surrounding pipeline: produces s_*, consumes m_*
interface jelly_colormap_lut_if #(
  parameter int USER_BITS   = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int COLOR_WIDTH = 24
);
  logic [USER_BITS-1:0]   s_user;
  logic                   s_first;
  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_valid;
  logic                   s_ready;

  logic [USER_BITS-1:0]   m_user;
  logic                   m_first;
  logic [DATA_WIDTH-1:0]  m_data;
  logic [COLOR_WIDTH-1:0] m_color;
  logic                   m_valid;
  logic                   m_ready;

  modport slave (
    input  s_user, s_first, s_data, s_valid, m_ready,
    output s_ready, m_user, m_first, m_data, m_color, m_valid
  );

  modport master (
    output s_user, s_first, s_data, s_valid, m_ready,
    input  s_ready, m_user, m_first, m_data, m_color, m_valid
  );
endinterface

// File: rtl/jelly_colormap_lut.sv
// jelly_colormap_lut
//   Multi-bank programmable colormap. Each index on the input stream is
//   looked up in the active bank's table and emitted with its colour two
//   enabled cycles later. Bank switches are armed through the cfg port and
//   only take effect on a frame's first pixel, so a palette swap never tears.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   cke             clock enable for the stream pipeline and bank state
//   cfg_we/bank/addr/wdata   table write (always active, ignores cke)
//   cfg_sel_bank, cfg_update arm a switch to a new display bank
//   cfg_pending     switch armed but not yet applied
//   active_bank     bank used for the current frame's lookups
//   bus             stream interface (slave modport)
module jelly_colormap_lut #(
  parameter int USER_WIDTH    = 0,
  parameter int DATA_WIDTH    = 8,
  parameter int COLOR_WIDTH   = 24,
  parameter int BANKS         = 2,
  parameter int BANK_BITS     = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter     INIT_COLORMAP = "GRAY"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,

  input  logic                   cfg_we,
  input  logic [BANK_BITS-1:0]   cfg_bank,
  input  logic [DATA_WIDTH-1:0]  cfg_addr,
  input  logic [COLOR_WIDTH-1:0] cfg_wdata,
  input  logic [BANK_BITS-1:0]   cfg_sel_bank,
  input  logic                   cfg_update,
  output logic                   cfg_pending,
  output logic [BANK_BITS-1:0]   active_bank,

  jelly_colormap_lut_if.slave    bus
);

  localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;
  localparam int ADDR_BITS = BANK_BITS + DATA_WIDTH;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int FIELD_W   = COLOR_WIDTH / 3;
  localparam logic [BANK_BITS:0] BANKS_W    = (BANK_BITS+1)'(BANKS);
  localparam logic [BANK_BITS-1:0] LAST_BANK = BANK_BITS'(BANKS - 1);

  // Power-up table image. GRAY puts the index MSB-first into each of the
  // three colour fields (truncated or zero-padded at the LSB end).
  function automatic logic [DEPTH*COLOR_WIDTH-1:0] init_table();
    logic [DEPTH*COLOR_WIDTH-1:0] t;
    logic [DATA_WIDTH-1:0]        idx;
    logic [COLOR_WIDTH-1:0]       c;
    t = '0;
    if (INIT_COLORMAP == "GRAY") begin
      for (int a = 0; a < DEPTH; a++) begin
        idx = DATA_WIDTH'(a);
        c   = '0;
        for (int f = 0; f < 3; f++) begin
          for (int k = 0; k < FIELD_W && k < DATA_WIDTH; k++) begin
            c[f*FIELD_W + FIELD_W - 1 - k] = idx[DATA_WIDTH-1-k];
          end
        end
        t[a*COLOR_WIDTH +: COLOR_WIDTH] = c;
      end
    end
    return t;
  endfunction

  localparam logic [DEPTH*COLOR_WIDTH-1:0] INIT_TABLE = init_table();

  // Table storage; never reset so written palettes survive a pipeline reset.
  logic [DEPTH-1:0][COLOR_WIDTH-1:0] table_mem = INIT_TABLE;

  logic [COLOR_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                   s0_valid_q, s0_valid_d;
  logic [USER_BITS-1:0]   s0_user_q,  s0_user_d;
  logic                   s0_first_q, s0_first_d;
  logic [DATA_WIDTH-1:0]  s0_data_q,  s0_data_d;

  logic                   m_valid_q,  m_valid_d;
  logic [USER_BITS-1:0]   m_user_q,   m_user_d;
  logic                   m_first_q,  m_first_d;
  logic [DATA_WIDTH-1:0]  m_data_q,   m_data_d;
  logic [COLOR_WIDTH-1:0] m_color_q,  m_color_d;

  logic [BANK_BITS-1:0]   active_q,   active_d;
  logic [BANK_BITS-1:0]   sel_q,      sel_d;
  logic                   pending_q,  pending_d;

  logic                   s_ready;
  logic                   en;
  logic                   upd_now;
  logic                   switch_now;
  logic [BANK_BITS-1:0]   sel_clamped;
  logic [BANK_BITS-1:0]   new_bank;
  logic [BANK_BITS-1:0]   beat_bank;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic                   wr_ok;

  always_comb begin
    s_ready     = !m_valid_q || bus.m_ready;
    en          = cke && s_ready;
    upd_now     = cke && cfg_update;
    sel_clamped = ({1'b0, cfg_sel_bank} >= BANKS_W) ? LAST_BANK : cfg_sel_bank;
    // An update in the same cycle as a frame start wins over the stored bank.
    new_bank    = upd_now ? sel_clamped : sel_q;
    switch_now  = en && bus.s_valid && bus.s_first && (pending_q || upd_now);
    beat_bank   = switch_now ? new_bank : active_q;
    rd_addr     = {beat_bank, bus.s_data};
    wr_ok       = {1'b0, cfg_bank} < BANKS_W;

    // Combinational read of the pre-write contents gives read-first behaviour.
    rd_data_d   = en ? table_mem[rd_addr] : rd_data_q;

    s0_valid_d  = s0_valid_q;
    s0_user_d   = s0_user_q;
    s0_first_d  = s0_first_q;
    s0_data_d   = s0_data_q;
    m_valid_d   = m_valid_q;
    m_user_d    = m_user_q;
    m_first_d   = m_first_q;
    m_data_d    = m_data_q;
    m_color_d   = m_color_q;
    if (en) begin
      s0_valid_d = bus.s_valid;
      s0_user_d  = bus.s_user;
      s0_first_d = bus.s_first;
      s0_data_d  = bus.s_data;
      m_valid_d  = s0_valid_q;
      m_user_d   = s0_user_q;
      m_first_d  = s0_first_q;
      m_data_d   = s0_data_q;
      m_color_d  = rd_data_q;
    end

    active_d  = active_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    if (upd_now) begin
      sel_d     = sel_clamped;
      pending_d = 1'b1;
    end
    if (switch_now) begin
      active_d  = new_bank;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && wr_ok) begin
      table_mem[{cfg_bank, cfg_addr}] <= cfg_wdata;
    end
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_user_q  <= '0;
      s0_first_q <= 1'b0;
      s0_data_q  <= '0;
      m_valid_q  <= 1'b0;
      m_user_q   <= '0;
      m_first_q  <= 1'b0;
      m_data_q   <= '0;
      m_color_q  <= '0;
      active_q   <= '0;
      sel_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_user_q  <= s0_user_d;
      s0_first_q <= s0_first_d;
      s0_data_q  <= s0_data_d;
      m_valid_q  <= m_valid_d;
      m_user_q   <= m_user_d;
      m_first_q  <= m_first_d;
      m_data_q   <= m_data_d;
      m_color_q  <= m_color_d;
      active_q   <= active_d;
      sel_q      <= sel_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_user   = m_user_q;
  assign bus.m_first  = m_first_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_color  = m_color_q;
  assign cfg_pending  = pending_q;
  assign active_bank  = active_q;

endmodule

// File: tb/tb_jelly_colormap_lut.sv
module tb_jelly_colormap_lut;
  localparam int DW = 8;
  localparam int CW = 24;
  localparam int BB = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cke;
  logic          cfg_we;
  logic [BB-1:0] cfg_bank;
  logic [DW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic [BB-1:0] cfg_sel_bank;
  logic          cfg_update;
  logic          cfg_pending;
  logic [BB-1:0] active_bank;

  int n_err = 0;
  int n_chk = 0;

  jelly_colormap_lut_if #(.USER_BITS(1), .DATA_WIDTH(DW), .COLOR_WIDTH(CW)) bus ();

  jelly_colormap_lut #(
    .USER_WIDTH(0), .DATA_WIDTH(DW), .COLOR_WIDTH(CW), .BANKS(2), .INIT_COLORMAP("GRAY")
  ) u_dut (
    .clk(clk), .reset(reset), .cke(cke),
    .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_sel_bank(cfg_sel_bank), .cfg_update(cfg_update),
    .cfg_pending(cfg_pending), .active_bank(active_bank),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] gray(input logic [DW-1:0] i);
    return {i, i, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic f);
    bus.s_data  = d;
    bus.s_first = f;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] c);
    step();
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.m_data),  32'(d));
    chk({tag, "_color"}, 32'(bus.m_color), 32'(c));
  endtask

  task automatic write_tbl(input logic [BB-1:0] b, input logic [DW-1:0] a, input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_bank = b; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int rcvd;
    logic stalled;
    logic [DW-1:0] hd;
    logic [CW-1:0] hc;

    reset = 1'b1; cke = 1'b1; cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0;
    cfg_wdata = '0; cfg_sel_bank = '0; cfg_update = 1'b0;
    bus.s_user = '0; bus.s_first = 1'b0; bus.s_data = '0; bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_color", 32'(bus.m_color), 32'd0);
    chk("rst_active",  32'(active_bank), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

    // back-to-back pass-through, 2-cycle latency
    bus.s_valid = 1'b1; bus.s_data = 8'h00;
    step();
    chk("lat_empty", 32'(bus.m_valid), 32'd0);
    bus.s_data = 8'h80;
    step();
    chk("pt0_valid", 32'(bus.m_valid), 32'd1);
    chk("pt0_color", 32'(bus.m_color), 32'h000000);
    bus.s_data = 8'hFF;
    step();
    chk("pt1_valid", 32'(bus.m_valid), 32'd1);
    chk("pt1_color", 32'(bus.m_color), 32'h808080);
    bus.s_valid = 1'b0;
    step();
    chk("pt2_valid", 32'(bus.m_valid), 32'd1);
    chk("pt2_color", 32'(bus.m_color), 32'hFFFFFF);
    step();
    chk("pt_drain", 32'(bus.m_valid), 32'd0);

    // 16-beat ramp with a 5-cycle output stall
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 80 && rcvd < 16; cyc++) begin
      bus.m_ready = !(cyc >= 6 && cyc < 11);
      bus.s_valid = (sent < 16);
      bus.s_data  = 8'(sent);
      #1;
      stalled = bus.m_valid && !bus.m_ready;
      if (stalled) begin
        chk("stall_s_ready", 32'(bus.s_ready), 32'd0);
        hd = bus.m_data;
        hc = bus.m_color;
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("ramp_data",  32'(bus.m_data),  32'(rcvd));
        chk("ramp_color", 32'(bus.m_color), 32'(gray(8'(rcvd))));
        rcvd++;
      end
      if (bus.s_valid && bus.s_ready) sent++;
      step();
      if (stalled) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data",  32'(bus.m_data),  32'(hd));
        chk("stall_color", 32'(bus.m_color), 32'(hc));
      end
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    chk("ramp_rcvd", 32'(rcvd), 32'd16);
    chk("ramp_sent", 32'(sent), 32'd16);
    step();

    // frame-aligned bank swap
    write_tbl(1'b1, 8'h10, 24'h123456);
    write_tbl(1'b1, 8'h30, 24'h777777);
    cfg_update = 1'b1; cfg_sel_bank = 1'b1;
    step();
    cfg_update = 1'b0;
    chk("arm_pending", 32'(cfg_pending), 32'd1);
    chk("arm_active",  32'(active_bank), 32'd0);
    send(8'h10, 1'b0);
    chk("mid_pending", 32'(cfg_pending), 32'd1);
    expect_out("mid_frame", 8'h10, 24'h101010);
    send(8'h10, 1'b1);
    chk("swap_active",  32'(active_bank), 32'd1);
    chk("swap_pending", 32'(cfg_pending), 32'd0);
    expect_out("swap", 8'h10, 24'h123456);
    chk("swap_first", 32'(bus.m_first), 32'd1);
    send(8'h10, 1'b0);
    expect_out("after_swap", 8'h10, 24'h123456);

    // update in the same cycle as the frame start
    cfg_update = 1'b1; cfg_sel_bank = 1'b0;
    send(8'h30, 1'b1);
    cfg_update = 1'b0;
    chk("same_active",  32'(active_bank), 32'd0);
    chk("same_pending", 32'(cfg_pending), 32'd0);
    expect_out("same_cycle", 8'h30, 24'h303030);

    // write/read collision on the active bank
    cfg_we = 1'b1; cfg_bank = 1'b0; cfg_addr = 8'h20; cfg_wdata = 24'hABCDEF;
    send(8'h20, 1'b0);
    cfg_we = 1'b0;
    expect_out("coll_old", 8'h20, 24'h202020);
    send(8'h20, 1'b0);
    expect_out("coll_new", 8'h20, 24'hABCDEF);

    // reset with beats in flight and a switch armed
    cfg_update = 1'b1; cfg_sel_bank = 1'b1;
    send(8'h01, 1'b1);
    cfg_update = 1'b0;
    chk("pre_rst_active", 32'(active_bank), 32'd1);
    cfg_update = 1'b1; cfg_sel_bank = 1'b0;
    step();
    cfg_update = 1'b0;
    chk("pre_rst_pending", 32'(cfg_pending), 32'd1);
    bus.s_valid = 1'b1; bus.s_data = 8'h02;
    step();
    bus.s_data = 8'h03;
    step();
    bus.s_valid = 1'b0;
    chk("inflight_valid", 32'(bus.m_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("midrst_valid",   32'(bus.m_valid), 32'd0);
    chk("midrst_active",  32'(active_bank), 32'd0);
    chk("midrst_pending", 32'(cfg_pending), 32'd0);
    reset = 1'b0;
    step();
    chk("midrst_drained", 32'(bus.m_valid), 32'd0);

    // clock enable low freezes the pipeline
    send(8'h05, 1'b0);
    cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cke_hold_valid", 32'(bus.m_valid), 32'd0);
      chk("cke_s_ready",    32'(bus.s_ready), 32'd1);
    end
    cke = 1'b1;
    expect_out("cke_resume", 8'h05, 24'h050505);
    step();
    chk("cke_single", 32'(bus.m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
